ysyx_23060332_wbu: RTL and testbench
====================================

YSYX_23060332_WBU -- requirements
Module: ysyx_23060332_wbu

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL provide rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide in_valid  input  1  EXU result valid.
REQ-004 SHALL provide in_ready  output  1  WBU can accept a result.
REQ-005 SHALL provide in_rd  input  5  destination register index.
REQ-006 SHALL provide in_result  input  32  ALU result, or load byte address.
REQ-007 SHALL provide in_wen  input  1  instruction writes rd.
REQ-008 SHALL provide in_load  input  1  instruction is a load.
REQ-009 SHALL provide in_funct3  input  3  load type: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu.
REQ-010 SHALL provide mem_req  output  1  one-cycle data-memory read request.
REQ-011 SHALL provide mem_addr  output  32  word-aligned read address.
REQ-012 SHALL provide mem_rvalid  input  1  read data valid.
REQ-013 SHALL provide mem_rdata  input  32  read word.
REQ-014 SHALL provide reg_wen  output  1  register-file write enable.
REQ-015 SHALL provide waddr  output  5  register-file write index.
REQ-016 SHALL provide wdata  output  32  register-file write data.
REQ-017 SHALL provide wb_done  output  1  one-cycle instruction-commit pulse to IFU.
REQ-018 SHALL provide ld_misalign  output  1  accompanies wb_done for a misaligned load.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD_REQ, MEM_WAIT, COMMIT.
REQ-020 SHALL set in_ready=1 only in IDLE with rst low; a transfer occurs on in_valid&in_ready.
REQ-021 SHALL latch rd, result, wen, load, funct3 on transfer; inputs are ignored outside IDLE.
REQ-022 SHALL go IDLE->COMMIT on a non-load transfer, with write data = in_result.
REQ-023 SHALL go IDLE->LOAD_REQ on a load transfer.
REQ-024 SHALL assert mem_req for exactly the one LOAD_REQ cycle, with mem_addr={result[31:2],2'b00}, then enter MEM_WAIT; mem_addr=0 otherwise.
REQ-025 SHALL stay in MEM_WAIT until mem_rvalid=1, then latch the extracted data and go to COMMIT; mem_rvalid in any other state is ignored.
REQ-026 SHALL extract load data by result[1:0]: lb/lbu select byte [8*a+7:8*a], sign- or zero-extended; lh/lhu select half [16*a[1]+15:16*a[1]], sign- or zero-extended; lw passes the word.
REQ-027 SHALL treat funct3 values 3, 6, 7 as lw.
REQ-028 SHALL flag misalignment (lh/lhu with a[0]=1; lw with a!=0), write data 0, and assert ld_misalign in COMMIT.
REQ-029 SHALL in COMMIT, for exactly one cycle, drive wb_done=1, waddr=rd, wdata=data, and reg_wen=wen&&(rd!=0), then return to IDLE.
REQ-030 SHALL drive reg_wen, waddr, wdata, wb_done, ld_misalign, mem_req and mem_addr from registered state only, with no combinational path from any input; each output is 0 outside its asserting state.
REQ-031 SHALL meet this latency: non-load accepted at cycle N commits at N+1; a load accepted at N has mem_req at N+1, and rvalid at M>=N+2 commits at M+1.
REQ-032 SHALL accept the next transfer at the earliest in the cycle after COMMIT, giving a back-to-back ALU throughput of 1 per 2 cycles.

Reset
REQ-033 SHALL on rst=1 force state IDLE and clear every output and latched field to 0, including in_ready.
REQ-034 SHALL abandon any in-flight load when rst is asserted mid-operation: no commit occurs, and a later stale mem_rvalid is ignored.

Verification
REQ-035 SHALL verify ALU writeback: rd=5, result=0xDEADBEEF, wen=1 accepted at N -> at N+1 reg_wen=1, waddr=5, wdata=0xDEADBEEF, wb_done=1.
REQ-036 SHALL verify x0 suppression: rd=0, wen=1 -> wb_done=1, reg_wen=0.
REQ-037 SHALL verify lb sign-extension: addr=0x80000003, rdata=0x80FF_0000 with rvalid 3 cycles after mem_req -> mem_addr=0x80000000, wdata=0xFFFFFF80, commit 1 cycle after rvalid.
REQ-038 SHALL verify lhu: addr a=2, rdata=0x8001_1234 -> wdata=0x00008001.
REQ-039 SHALL verify misaligned lw: addr=0x80000001 -> wdata=0, ld_misalign=1, wb_done=1.
REQ-040 SHALL verify reset mid-load: rst during MEM_WAIT, then rvalid -> no reg_wen or wb_done, in_ready=1 after reset.

Source files
------------

// File: rtl/ysyx_23060332_wbu.sv
// Writeback unit: takes one EXU result at a time, performs the data-memory read for loads,
// extracts and extends the loaded value, then commits to the register file for one cycle.
module ysyx_23060332_wbu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_result,
   input  logic        in_wen,
   input  logic        in_load,
   input  logic [2:0]  in_funct3,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        reg_wen,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic        wb_done,
   output logic        ld_misalign
);

   typedef enum logic [1:0] {IDLE, LOAD_REQ, MEM_WAIT, COMMIT} state_t;

   state_t      state_q, state_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] result_q, result_d;
   logic        wen_q, wen_d;
   logic        load_q, load_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] data_q, data_d;
   logic        mis_q, mis_d;

   logic [1:0]  byte_off;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ext_data;
   logic        ext_mis;

   // Load extraction works on the latched byte address and the live read word.
   always_comb begin
      byte_off = result_q[1:0];
      byte_v   = mem_rdata[{byte_off, 3'b000} +: 8];
      half_v   = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ext_data = mem_rdata;
      ext_mis  = 1'b0;
      case (funct3_q)
         3'd0: ext_data = {{24{byte_v[7]}}, byte_v};
         3'd4: ext_data = {24'd0, byte_v};
         3'd1: begin
            ext_data = {{16{half_v[15]}}, half_v};
            ext_mis  = byte_off[0];
         end
         3'd5: begin
            ext_data = {16'd0, half_v};
            ext_mis  = byte_off[0];
         end
         default: begin
            ext_data = mem_rdata;
            ext_mis  = (byte_off != 2'd0);
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      result_d = result_q;
      wen_d    = wen_q;
      load_d   = load_q;
      funct3_d = funct3_q;
      data_d   = data_q;
      mis_d    = mis_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rd_d     = in_rd;
               result_d = in_result;
               wen_d    = in_wen;
               load_d   = in_load;
               funct3_d = in_funct3;
               mis_d    = 1'b0;
               if (in_load) begin
                  state_d = LOAD_REQ;
               end else begin
                  data_d  = in_result;
                  state_d = COMMIT;
               end
            end
         end
         LOAD_REQ: state_d = MEM_WAIT;
         MEM_WAIT: begin
            if (mem_rvalid) begin
               data_d  = ext_mis ? 32'd0 : ext_data;
               mis_d   = ext_mis;
               state_d = COMMIT;
            end
         end
         COMMIT:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rd_q     <= 5'd0;
         result_q <= 32'd0;
         wen_q    <= 1'b0;
         load_q   <= 1'b0;
         funct3_q <= 3'd0;
         data_q   <= 32'd0;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         wen_q    <= wen_d;
         load_q   <= load_d;
         funct3_q <= funct3_d;
         data_q   <= data_d;
         mis_q    <= mis_d;
      end
   end

   // Outputs are pure decodes of registered state; only in_ready also looks at rst.
   assign in_ready = (state_q == IDLE) && !rst;

   always_comb begin
      mem_req     = (state_q == LOAD_REQ);
      mem_addr    = mem_req ? {result_q[31:2], 2'b00} : 32'd0;
      wb_done     = (state_q == COMMIT);
      reg_wen     = wb_done && wen_q && (rd_q != 5'd0);
      waddr       = wb_done ? rd_q : 5'd0;
      wdata       = wb_done ? data_q : 32'd0;
      ld_misalign = wb_done && load_q && mis_q;
   end

endmodule

// File: tb/tb_ysyx_23060332_wbu.sv
// Randomized bench for the writeback unit, checked against an arithmetic model of the load rules.
module tb_ysyx_23060332_wbu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic        in_wen;
   logic        in_load;
   logic [2:0]  in_funct3;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        reg_wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        wb_done;
   logic        ld_misalign;

   int n_cmp = 0;
   int n_bad = 0;

   ysyx_23060332_wbu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_result(in_result), .in_wen(in_wen), .in_load(in_load),
      .in_funct3(in_funct3), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_wen(reg_wen),
      .waddr(waddr), .wdata(wdata), .wb_done(wb_done), .ld_misalign(ld_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: load result from the byte address and the word read, using plain arithmetic.
   function automatic void ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] rd_word,
                                    output logic [31:0] data, output logic mis);
      int unsigned a, b, h;
      a = addr % 4;
      b = (rd_word / (32'd1 << (8 * a))) % 256;
      h = (rd_word / (32'd1 << (16 * (a / 2)))) % 65536;
      mis  = 1'b0;
      data = 32'd0;
      case (f3)
         3'd0: data = (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd4: data = b;
         3'd1: begin mis = (a % 2) != 0; data = (h >= 32768) ? h + 32'hFFFF0000 : h; end
         3'd5: begin mis = (a % 2) != 0; data = h; end
         default: begin mis = (a != 0); data = rd_word; end
      endcase
      if (mis) data = 32'd0;
   endfunction

   task automatic garbage_inputs();
      in_valid  = 1'($urandom % 2);
      in_rd     = 5'($urandom);
      in_result = $urandom;
      in_wen    = 1'($urandom % 2);
      in_load   = 1'($urandom % 2);
      in_funct3 = 3'($urandom);
   endtask

   task automatic run_txn(input string nm, input logic [4:0] rd, input logic [31:0] res,
                          input logic wen, input logic ld, input logic [2:0] f3,
                          input logic [31:0] rword, input int dly);
      logic [31:0] exp_data;
      logic        exp_mis;
      @(negedge clk);
      chk({nm, ".ready"}, 32'(in_ready), 32'd1);
      chk({nm, ".idle_done"}, 32'(wb_done), 32'd0);
      in_valid = 1'b1; in_rd = rd; in_result = res; in_wen = wen;
      in_load = ld; in_funct3 = f3;
      @(negedge clk);
      garbage_inputs();
      chk({nm, ".busy"}, 32'(in_ready), 32'd0);
      if (!ld) begin
         exp_data = res;
         exp_mis  = 1'b0;
      end else begin
         ref_load(f3, res, rword, exp_data, exp_mis);
         chk({nm, ".mem_req"}, 32'(mem_req), 32'd1);
         chk({nm, ".mem_addr"}, mem_addr, res - (res % 4));
         chk({nm, ".early_done"}, 32'(wb_done), 32'd0);
         mem_rvalid = 1'($urandom % 2);
         mem_rdata  = $urandom;
         @(negedge clk);
         garbage_inputs();
         chk({nm, ".req_off"}, 32'(mem_req), 32'd0);
         chk({nm, ".addr_off"}, mem_addr, 32'd0);
         for (int i = 1; i < dly; i++) begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            @(negedge clk);
            garbage_inputs();
            chk({nm, ".wait_done"}, 32'(wb_done), 32'd0);
         end
         mem_rvalid = 1'b1;
         mem_rdata  = rword;
         @(negedge clk);
         mem_rvalid = 1'b0;
      end
      chk({nm, ".wb_done"}, 32'(wb_done), 32'd1);
      chk({nm, ".reg_wen"}, 32'(reg_wen), 32'(wen && (rd != 5'd0)));
      chk({nm, ".waddr"}, 32'(waddr), 32'(rd));
      chk({nm, ".wdata"}, wdata, exp_data);
      chk({nm, ".misalign"}, 32'(ld_misalign), 32'(exp_mis));
      chk({nm, ".commit_req"}, 32'(mem_req), 32'd0);
      $display("txn %s rd=%0d res=0x%08h load=%0b f3=%0d rword=0x%08h -> wdata=0x%08h exp=0x%08h",
               nm, rd, res, ld, f3, rword, wdata, exp_data);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_result = 32'd0; in_wen = 1'b0;
      in_load = 1'b0; in_funct3 = 3'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.ready", 32'(in_ready), 32'd0);
      chk("rst.wb_done", 32'(wb_done), 32'd0);
      chk("rst.reg_wen", 32'(reg_wen), 32'd0);
      chk("rst.wdata", wdata, 32'd0);
      chk("rst.mem_req", 32'(mem_req), 32'd0);
      chk("rst.mem_addr", mem_addr, 32'd0);
      chk("rst.misalign", 32'(ld_misalign), 32'd0);
      rst = 1'b0;

      run_txn("alu",    5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 32'd0, 1);
      run_txn("x0",     5'd0,  32'h12345678, 1'b1, 1'b0, 3'd0, 32'd0, 1);
      run_txn("lb",     5'd7,  32'h80000003, 1'b1, 1'b1, 3'd0, 32'h80FF0000, 3);
      run_txn("lhu",    5'd9,  32'h80000002, 1'b1, 1'b1, 3'd5, 32'h80011234, 1);
      run_txn("lw_mis", 5'd3,  32'h80000001, 1'b1, 1'b1, 3'd2, 32'hCAFEF00D, 2);

      // Reset while waiting for memory: the load must vanish and a late rvalid be ignored.
      @(negedge clk);
      in_valid = 1'b1; in_rd = 5'd4; in_result = 32'h80000000; in_wen = 1'b1;
      in_load = 1'b1; in_funct3 = 3'd2;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstld.ready_in_rst", 32'(in_ready), 32'd0);
      chk("rstld.done_in_rst", 32'(wb_done), 32'd0);
      rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h11111111;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rstld.done", 32'(wb_done), 32'd0);
      chk("rstld.reg_wen", 32'(reg_wen), 32'd0);
      chk("rstld.ready", 32'(in_ready), 32'd1);
      chk("rstld.mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      chk("rstld.done2", 32'(wb_done), 32'd0);
      $display("txn rst_mid_load -> no commit");

      for (int k = 0; k < 150; k++) begin
         run_txn("rnd", 5'($urandom), $urandom, 1'($urandom % 2), 1'($urandom % 2),
                 3'($urandom), $urandom, 1 + int'($urandom % 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
